// File: rtl/req_ack_responder.sv
// rtl/req_ack_responder.sv - fixed-latency request/acknowledge responder with saturating stats
module req_ack_responder #(
  parameter int LATENCY = 4,
  parameter int DW      = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [DW-1:0]    data_i,
  input  logic             flush_i,
  output logic             ack_o,
  output logic [DW-1:0]    data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] req_cnt_o,
  output logic [CNT_W-1:0] ack_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  // Popcount width for in-flight entries, and a sum width wide enough
  // that adding a full pipeline's worth of drops cannot overflow.
  localparam int PW = $clog2(LATENCY + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [DW-1:0]      data_q [LATENCY];
  logic [DW-1:0]      data_d [LATENCY];
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]      inflight;
  logic [SW-1:0]      drop_sum;

  // Next-state: shift the pipeline, flush kills everything past stage 1,
  // and counters advance with saturation.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = req_i;
    data_d[0]  = data_i;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1] & ~flush_i;
      data_d[i]  = data_q[i-1];
    end
    busy_d = |valid_d;

    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + PW'(valid_q[i]);
    end
    drop_sum = SW'(drop_cnt_q) + SW'(inflight);

    req_cnt_d = req_cnt_q;
    if (req_i && (req_cnt_q != CNT_MAX)) begin
      req_cnt_d = req_cnt_q + CNT_W'(1);
    end

    ack_cnt_d = ack_cnt_q;
    if (valid_q[LATENCY-1] && !flush_i && (ack_cnt_q != CNT_MAX)) begin
      ack_cnt_d = ack_cnt_q + CNT_W'(1);
    end

    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      if (drop_sum > SW'(CNT_MAX)) begin
        drop_cnt_d = CNT_MAX;
      end else begin
        drop_cnt_d = drop_sum[CNT_W-1:0];
      end
    end
  end

  // State registers; reset outranks flush and request.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      busy_q     <= 1'b0;
      req_cnt_q  <= '0;
      ack_cnt_q  <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      req_cnt_q  <= req_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign ack_o      = valid_q[LATENCY-1];
  assign data_o     = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
  assign busy_o     = busy_q;
  assign req_cnt_o  = req_cnt_q;
  assign ack_cnt_o  = ack_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// tb/tb_req_ack_responder.sv - scoreboard bench for req_ack_responder
module tb_req_ack_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        flush_i = 1'b0;
  logic        ack_o;
  logic [7:0]  data_o;
  logic        busy_o;
  logic [15:0] req_cnt_o, ack_cnt_o, drop_cnt_o;

  logic        rst_s = 1'b1;
  logic        req_s = 1'b0;
  logic [7:0]  data_s = '0;
  logic        flush_s = 1'b0;
  logic        ack_s;
  logic [7:0]  dout_s;
  logic        busy_s;
  logic [2:0]  req_cnt_s, ack_cnt_s, drop_cnt_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  req_ack_responder #(.LATENCY(LAT), .DW(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .flush_i(flush_i),
    .ack_o(ack_o), .data_o(data_o), .busy_o(busy_o),
    .req_cnt_o(req_cnt_o), .ack_cnt_o(ack_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  req_ack_responder #(.LATENCY(LAT), .DW(8), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst_s), .req_i(req_s), .data_i(data_s), .flush_i(flush_s),
    .ack_o(ack_s), .data_o(dout_s), .busy_o(busy_s),
    .req_cnt_o(req_cnt_s), .ack_cnt_o(ack_cnt_s), .drop_cnt_o(drop_cnt_s)
  );

  // Scoreboard: every cycle the ack/data pair must match the queue head or be idle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        if (ack_o !== 1'b1 || data_o !== sb[0].data) begin
          failures++;
          $display("FAIL sb_ack cyc=%0d ack=%b data=%h expected ack=1 data=%h",
                   cyc, ack_o, data_o, sb[0].data);
        end
        void'(sb.pop_front());
      end else begin
        if (ack_o !== 1'b0 || data_o !== 8'h00) begin
          failures++;
          $display("FAIL sb_idle cyc=%0d ack=%b data=%h expected ack=0 data=00",
                   cyc, ack_o, data_o);
        end
      end
    end
  end

  // Drive one edge's inputs, update expectations, and return after outputs settle.
  task automatic step(input logic r, input logic [7:0] d, input logic f, input logic rs);
    exp_t e;
    rst = rs; req_i = r; data_i = d; flush_i = f;
    if (rs) begin
      sb.delete();
    end else begin
      if (f) sb.delete();
      if (r) begin
        e.due = cyc + LAT;
        e.data = d;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    checks++;
    if (ack_o !== 1'b0 || data_o !== 8'h00 || busy_o !== 1'b0 ||
        req_cnt_o !== 16'd0 || ack_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_vals ack=%b data=%h busy=%b req=%0d ack_cnt=%0d drop=%0d expected all 0",
               ack_o, data_o, busy_o, req_cnt_o, ack_cnt_o, drop_cnt_o);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int n = 2; n <= 6; n++) begin
      checks++;
      if (busy_o !== (n <= 5)) begin
        failures++;
        $display("FAIL single_busy edge=%0d busy=%b expected %b", n, busy_o, (n <= 5));
      end
      if (n == 5) begin
        checks++;
        if (ack_o !== 1'b1 || data_o !== 8'hA5) begin
          failures++;
          $display("FAIL single_ack ack=%b data=%h expected 1 a5", ack_o, data_o);
        end
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checks++;
    if (ack_cnt_o !== 16'd1 || req_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL single_cnt req=%0d ack=%0d expected 1 1", req_cnt_o, ack_cnt_o);
    end
  endtask

  task automatic test_spaced();
    int acks = 0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      step((n == 1 || n == 10), 8'(n), 1'b0, 1'b0);
      if (ack_o === 1'b1) acks++;
    end
    checks++;
    if (acks != 2 || ack_cnt_o !== 16'd2) begin
      failures++;
      $display("FAIL spaced_acks seen=%0d ack_cnt=%0d expected 2 2", acks, ack_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    int maxrun = 0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int n = 1; n <= 14; n++) begin
      step((n >= 3 && n <= 8), 8'(n - 2), 1'b0, 1'b0);
      if (n == 8) begin
        checks++;
        if (req_cnt_o - ack_cnt_o !== 16'd4) begin
          failures++;
          $display("FAIL burst_inflight diff=%0d expected 4", req_cnt_o - ack_cnt_o);
        end
      end
      if (ack_o === 1'b1) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    checks++;
    if (maxrun != 6 || req_cnt_o !== 16'd6 || ack_cnt_o !== 16'd6 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL burst_summary run=%0d req=%0d ack=%0d busy=%b expected 6 6 6 0",
               maxrun, req_cnt_o, ack_cnt_o, busy_o);
    end
  endtask

  task automatic test_flush();
    int acks = 0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    checks++;
    if (drop_cnt_o !== 16'd2 || busy_o !== 1'b1 || ack_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_edge drop=%0d busy=%b ack=%b expected 2 1 0", drop_cnt_o, busy_o, ack_o);
    end
    for (int n = 4; n <= 9; n++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (ack_o === 1'b1) acks++;
    end
    checks++;
    if (acks != 1 || ack_cnt_o !== 16'd1 || req_cnt_o !== 16'd3 || drop_cnt_o !== 16'd2) begin
      failures++;
      $display("FAIL flush_summary acks=%0d ack_cnt=%0d req=%0d drop=%0d expected 1 1 3 2",
               acks, ack_cnt_o, req_cnt_o, drop_cnt_o);
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    checks++;
    if (ack_o !== 1'b0 || data_o !== 8'h00 || busy_o !== 1'b0 || req_cnt_o !== 16'd0 ||
        ack_cnt_o !== 16'd0 || drop_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL midreset_vals ack=%b data=%h busy=%b req=%0d ack_cnt=%0d drop=%0d expected all 0",
               ack_o, data_o, busy_o, req_cnt_o, ack_cnt_o, drop_cnt_o);
    end
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    for (int n = 5; n <= 9; n++) begin
      if (n == 8) begin
        checks++;
        if (ack_o !== 1'b1 || data_o !== 8'hC3) begin
          failures++;
          $display("FAIL midreset_ack ack=%b data=%h expected 1 c3", ack_o, data_o);
        end
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checks++;
    if (drop_cnt_o !== 16'd0 || ack_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL midreset_cnt drop=%0d ack=%0d expected 0 1", drop_cnt_o, ack_cnt_o);
    end
  endtask

  task automatic test_saturation();
    int exp_req;
    rst_s = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst_s = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      req_s = 1'b1;
      data_s = 8'(n);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      exp_req = (n > 7) ? 7 : n;
      checks++;
      if (req_cnt_s !== 3'(exp_req)) begin
        failures++;
        $display("FAIL sat_req n=%0d got=%0d expected %0d", n, req_cnt_s, exp_req);
      end
    end
    req_s = 1'b0;
    for (int n = 0; n < 6; n++) step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ack_cnt_s !== 3'd7 || req_cnt_s !== 3'd7 || drop_cnt_s !== 3'd0) begin
      failures++;
      $display("FAIL sat_final req=%0d ack=%0d drop=%0d expected 7 7 0", req_cnt_s, ack_cnt_s, drop_cnt_s);
    end
  endtask

  initial begin
    @(negedge clk);
    #1;
    test_reset();
    test_single();
    test_spaced();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
